// File: rtl/step_sequencer.sv
// Step/result initiator: issues counted enable strobes, waits a programmable gap,
// captures the result bus into a show-ahead FIFO. Optional capture timestamps: STEP_SEQ_TIMESTAMP_EN.
module step_sequencer #(
    parameter int DATA_W = 32,
    parameter int GAP_W  = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  step_count,
    input  logic [GAP_W-1:0]  gap,
    input  logic              abort,
    output logic              enable_out,
    input  logic [DATA_W-1:0] result_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef STEP_SEQ_TIMESTAMP_EN
    output logic [CNT_W-1:0]  rd_stamp,
`endif
    output logic [CNT_W-1:0]  steps_done
);

    localparam int AW = $clog2(DEPTH);
`ifdef STEP_SEQ_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_W + CNT_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fill_q, fill_d;
    logic               push, pop, do_push, drop, ovf_clr;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

`ifdef STEP_SEQ_TIMESTAMP_EN
    logic [CNT_W-1:0]   ts_q, ts_d;
    assign ts_d     = ts_q + CNT_ONE;
    assign wr_entry = {ts_q, result_in};
`else
    assign wr_entry = result_in;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        steps_d   = steps_q;
        push      = 1'b0;
        ovf_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    count_d = step_count;
                    gap_d   = gap;
                    steps_d = '0;
                    ovf_clr = 1'b1;
                    state_d = (step_count == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                steps_d   = steps_q + CNT_ONE;
                gap_cnt_d = (gap_q == '0) ? GAP_ONE : gap_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                gap_cnt_d = gap_cnt_q - GAP_ONE;
                if (gap_cnt_q <= GAP_ONE) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_d = (steps_q == count_q) ? ST_DONE : ST_PULSE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides whatever the active state decided, including the capture push.
        if (abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            push      = 1'b0;
            steps_d   = steps_q;
            gap_cnt_d = gap_cnt_q;
        end
        enable_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // FIFO bookkeeping: a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop      = rd_en && (fill_q != '0);
        do_push  = push && ((fill_q != FULL_LVL) || pop);
        drop     = push && (fill_q == FULL_LVL) && !pop;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fill_d   = fill_q;
        if (do_push && !pop) fill_d = fill_q + FILL_ONE;
        else if (pop && !do_push) fill_d = fill_q - FILL_ONE;
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            steps_q    <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
`ifdef STEP_SEQ_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            steps_q    <= steps_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
`ifdef STEP_SEQ_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign rd_valid   = (fill_q != '0);
    assign rd_data    = rd_valid ? head[DATA_W-1:0] : '0;
`ifdef STEP_SEQ_TIMESTAMP_EN
    assign rd_stamp   = rd_valid ? head[ENTRY_W-1:DATA_W] : '0;
`endif
    assign enable_out = enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign steps_done = steps_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: strobe timing, capture values, FIFO overflow/full-pop, abort, async reset.
module tb_step_sequencer;

    localparam int DATA_W = 32;
    localparam int GAP_W  = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rd_en = 1'b0;
    logic [CNT_W-1:0]  step_count = '0;
    logic [GAP_W-1:0]  gap = '0;
    logic [DATA_W-1:0] result_in;
    logic              enable_out, rd_valid, busy, done, overflow;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  steps_done;
`ifdef STEP_SEQ_TIMESTAMP_EN
    logic [CNT_W-1:0]  rd_stamp;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign result_in = {16'hA5A5, cyc[15:0]};

    step_sequencer #(.DATA_W(DATA_W), .GAP_W(GAP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .step_count(step_count), .gap(gap),
        .abort(abort), .enable_out(enable_out), .result_in(result_in), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .overflow(overflow),
`ifdef STEP_SEQ_TIMESTAMP_EN
        .rd_stamp(rd_stamp),
`endif
        .steps_done(steps_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int c);
        return {16'hA5A5, c[15:0]};
    endfunction

    task automatic start_run(input int cnt, input int g, output int s);
        step_count = CNT_W'(cnt);
        gap        = GAP_W'(g);
        start      = 1'b1;
        s          = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic pop;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        int s;
        int dn_at;
        int en_cnt;
        int dn_cnt;
        logic [31:0] en_m, dn_m, bz_m, rv_m;

        // ---- reset values
        tick(); tick(); tick();
        check("rst_enable", enable_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_steps", steps_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        tick();

        // ---- 3 steps, gap 4: pulses 6 cycles apart, captures at s+6/12/18
        en_m = '0; dn_m = '0; bz_m = '0; rv_m = '0;
        start_run(3, 4, s);
        en_m[1] = enable_out; dn_m[1] = done; bz_m[1] = busy; rv_m[1] = rd_valid;
        for (int i = 2; i <= 22; i++) begin
            tick();
            en_m[i] = enable_out; dn_m[i] = done; bz_m[i] = busy; rv_m[i] = rd_valid;
        end
        check("t1_enable_mask", en_m, 32'h0000_2082);
        check("t1_done_mask", dn_m, 32'h0008_0000);
        check("t1_busy_mask", bz_m, 32'h000F_FFFE);
        check("t1_rd_valid_mask", rv_m, 32'h007F_FF80);
        check("t1_steps", steps_done, 3);
        check("t1_data0", rd_data, smp(s + 6)); pop();
        check("t1_data1", rd_data, smp(s + 12)); pop();
        check("t1_data2", rd_data, smp(s + 18)); pop();
        check("t1_empty", rd_valid, 0);

        // ---- zero-length run: no strobe, done in the cycle after start is sampled
        start_run(0, 5, s);
        check("t2_done_hi", done, 1);
        check("t2_busy_hi", busy, 1);
        check("t2_no_enable0", enable_out, 0);
        tick();
        check("t2_done_lo", done, 0);
        check("t2_busy_lo", busy, 0);
        check("t2_no_enable1", enable_out, 0);
        check("t2_steps", steps_done, 0);
        check("t2_fifo_empty", rd_valid, 0);

        // ---- 10 steps, gap 1, no reads: 8 stored, 2 dropped
        dn_at = 0; en_cnt = 0;
        start_run(10, 1, s);
        for (int i = 1; i <= 33; i++) begin
            if (i > 1) tick();
            if (done) dn_at = i;
            if (enable_out) en_cnt++;
        end
        check("t3_done_at", dn_at, 31);
        check("t3_enable_cnt", en_cnt, 10);
        check("t3_steps", steps_done, 10);
        check("t3_overflow", overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t3_data%0d", k), rd_data, smp(s + 3 * k));
            pop();
        end
        check("t3_empty", rd_valid, 0);
        check("t3_overflow_sticky", overflow, 1);

        // ---- full FIFO with push and pop on the same edge
        start_run(9, 1, s);
        check("t4_overflow_clr", overflow, 0);
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (i == 27) begin
                check("t4_full_head", rd_data, smp(s + 3));
                rd_en = 1'b1;
            end
            if (i == 28) begin
                rd_en = 1'b0;
                check("t4_head_adv", rd_data, smp(s + 6));
                check("t4_no_overflow", overflow, 0);
            end
        end
        check("t4_steps", steps_done, 9);
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("t4_data%0d", k), rd_data, smp(s + 3 * k));
            pop();
        end
        check("t4_empty", rd_valid, 0);
        check("t4_overflow_end", overflow, 0);

        // ---- abort in WAIT of step 2 of 5
        en_cnt = 0; dn_cnt = 0;
        start_run(5, 2, s);
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) tick();
            if (enable_out) en_cnt++;
            if (done) dn_cnt++;
            if (i == 6) abort = 1'b1;
            if (i == 7) begin
                abort = 1'b0;
                check("t5_idle_next", busy, 0);
            end
        end
        check("t5_enable_cnt", en_cnt, 2);
        check("t5_no_done", dn_cnt, 0);
        check("t5_steps", steps_done, 2);
        check("t5_one_entry", rd_valid, 1);
        check("t5_data", rd_data, smp(s + 4));

        // ---- async reset during PULSE, FIFO still holding the abort-run entry
        start_run(2, 3, s);
        check("t6_pulse", enable_out, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_enable_drop", enable_out, 0);
        check("t6_busy", busy, 0);
        check("t6_steps", steps_done, 0);
        check("t6_rd_valid", rd_valid, 0);
        check("t6_rd_data", rd_data, 0);
        check("t6_done", done, 0);
        @(negedge clk) reset = 1'b1;
        tick();
        en_m = '0; dn_at = 0;
        start_run(1, 1, s);
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) tick();
            en_m[i] = enable_out;
            if (done) dn_at = i;
        end
        check("t6_post_enable", en_m, 32'h0000_0002);
        check("t6_post_done_at", dn_at, 4);
        check("t6_post_data", rd_data, smp(s + 3));
        check("t6_post_steps", steps_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
